// File: rtl/dmem_arbiter.sv
// Data memory port arbiter: the MEM stage (CPU) owns the memory by default and the
// debug/loader unit is slotted in on idle cycles or forced in after a bounded wait.
module dmem_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clkEnable,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DBG_READ = 2'd1,
    S_DBG_ACK  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_stateNext;
  logic [CNT_W-1:0]  r_starveCnt;
  logic              r_dbgAck;
  logic [DATA_W-1:0] r_dbgRdata;
  logic              w_starved;
  logic              w_dbgGrant;

  // A limit of zero makes the counter compare true from the start, so DBG always wins.
  assign w_starved  = (r_starveCnt == LIMIT);
  assign w_dbgGrant = (r_state == S_IDLE) && dbg_req && (!cpu_req || w_starved);

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE:     if (w_dbgGrant) w_stateNext = S_DBG_READ;
      S_DBG_READ: w_stateNext = S_DBG_ACK;
      S_DBG_ACK:  w_stateNext = S_IDLE;
      default:    w_stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_dbgAck   <= 1'b0;
      r_dbgRdata <= '0;
    end else if (clkEnable) begin
      r_state  <= w_stateNext;
      r_dbgAck <= (r_state == S_DBG_READ);
      if (r_state == S_DBG_READ) r_dbgRdata <= mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_starveCnt <= '0;
    end else if (clkEnable) begin
      if (!dbg_req || w_dbgGrant) begin
        r_starveCnt <= '0;
      end else if ((r_state == S_IDLE) && cpu_req && !w_starved) begin
        r_starveCnt <= r_starveCnt + CNT_W'(1);
      end
    end
  end

  // Write enables are gated so a frozen pipeline or a reset never disturbs memory.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = cpu_req && cpu_we && clkEnable && !reset;
    if (w_dbgGrant) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_we    = dbg_we && clkEnable && !reset;
    end
  end

  assign cpu_stall = cpu_req && w_dbgGrant && !reset;
  assign cpu_rdata = mem_rdata;
  assign dbg_ack   = r_dbgAck;
  assign dbg_rdata = r_dbgRdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 16x32 synchronous-read memory model
// (read-before-write) attached to the arbiter's memory pins.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        clkEnable;
  logic        cpu_req, cpu_we;
  logic [3:0]  cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dbg_req, dbg_we;
  logic [3:0]  dbg_addr;
  logic [31:0] dbg_wdata, dbg_rdata;
  logic        dbg_ack;
  logic        mem_we;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] memArray [16];

  int nChecks = 0;
  int nFails  = 0;

  dmem_arbiter #(.DATA_W(32), .ADDR_W(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .reset(reset), .clkEnable(clkEnable),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: old word is read out in the same cycle a write lands.
  initial for (int i = 0; i < 16; i++) memArray[i] = 32'hA5A5_0000 | 32'(i);
  always @(posedge clk) begin
    mem_rdata <= memArray[mem_addr];
    if (mem_we) memArray[mem_addr] <= mem_wdata;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic cReq, input logic cWe, input logic [3:0] cAddr,
                               input logic [31:0] cWdata, input logic dReq, input logic dWe,
                               input logic [3:0] dAddr, input logic [31:0] dWdata);
    cpu_req = cReq; cpu_we = cWe; cpu_addr = cAddr; cpu_wdata = cWdata;
    dbg_req = dReq; dbg_we = dWe; dbg_addr = dAddr; dbg_wdata = dWdata;
    #1;
  endtask

  task automatic stepCycle;
    @(posedge clk);
    #1;
  endtask

  // Hold DBG read of addr 3 against a busy CPU; the forced grant lands on cycle 9.
  task automatic starveRound(input string tag);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1, 0, 4'd0, 32'h0, 1, 0, 4'd3, 32'h0);
      checkOutput({tag, "_noStall"}, cpu_stall, 0);
      stepCycle();
    end
    applyStimulus(1, 0, 4'd0, 32'h0, 1, 0, 4'd3, 32'h0);
    checkOutput({tag, "_stall"}, cpu_stall, 1);
    checkOutput({tag, "_addr"}, mem_addr, 4'd3);
    stepCycle();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Test 1: reset with CPU storing and a would-be DBG write
    reset = 1; clkEnable = 1;
    applyStimulus(1, 1, 4'd0, 32'h1111_1111, 0, 0, 4'd0, 32'h0);
    stepCycle();
    checkOutput("rstMemWe", mem_we, 0);
    checkOutput("rstStall", cpu_stall, 0);
    checkOutput("rstAck", dbg_ack, 0);
    checkOutput("rstRdata", dbg_rdata, 32'h0);
    applyStimulus(0, 0, 4'd0, 32'h0, 1, 1, 4'd1, 32'h2222_2222);
    checkOutput("rstDbgMemWe", mem_we, 0);
    stepCycle();
    reset = 0;
    applyStimulus(0, 0, 4'd0, 32'h0, 0, 0, 4'd0, 32'h0);
    checkOutput("postRstAck", dbg_ack, 0);
    stepCycle();

    // Test 2: DBG write on an idle CPU, then a CPU readback
    applyStimulus(0, 0, 4'd0, 32'h0, 1, 1, 4'd5, 32'hDEAD_BEEF);
    checkOutput("t2MemWe", mem_we, 1);
    checkOutput("t2MemAddr", mem_addr, 4'd5);
    checkOutput("t2MemWdata", mem_wdata, 32'hDEAD_BEEF);
    checkOutput("t2AckT", dbg_ack, 0);
    stepCycle();
    checkOutput("t2AckT1", dbg_ack, 0);
    checkOutput("t2MemWeT1", mem_we, 0);
    stepCycle();
    checkOutput("t2AckT2", dbg_ack, 1);
    checkOutput("t2OldWord", dbg_rdata, 32'hA5A5_0005);
    applyStimulus(1, 0, 4'd5, 32'h0, 0, 0, 4'd0, 32'h0);
    stepCycle();
    checkOutput("t2AckT3", dbg_ack, 0);
    checkOutput("t2CpuLoad", cpu_rdata, 32'hDEAD_BEEF);
    applyStimulus(0, 0, 4'd0, 32'h0, 0, 0, 4'd0, 32'h0);
    stepCycle();

    // Test 3: starvation; dbg_req stays high so a second round checks the counter restarted
    starveRound("t3a");
    applyStimulus(1, 0, 4'd0, 32'h0, 1, 0, 4'd3, 32'h0);
    checkOutput("t3StallT1", cpu_stall, 0);
    checkOutput("t3AddrT1", mem_addr, 4'd0);
    stepCycle();
    checkOutput("t3AckT2", dbg_ack, 1);
    checkOutput("t3Rdata", dbg_rdata, 32'hA5A5_0003);
    stepCycle();
    starveRound("t3b");
    stepCycle();
    checkOutput("t3bAck", dbg_ack, 1);
    applyStimulus(0, 0, 4'd0, 32'h0, 0, 0, 4'd0, 32'h0);
    stepCycle();

    // Test 4: reset while in S_DBG_READ, then immediate re-grant
    applyStimulus(0, 0, 4'd9, 32'h0, 1, 0, 4'd3, 32'h0);
    checkOutput("t4Grant", mem_addr, 4'd3);
    stepCycle();
    reset = 1;
    #1;
    checkOutput("t4RstStall", cpu_stall, 0);
    stepCycle();
    reset = 0;
    #1;
    checkOutput("t4NoAck", dbg_ack, 0);
    checkOutput("t4Regrant", mem_addr, 4'd3);
    stepCycle();
    checkOutput("t4AckT1", dbg_ack, 0);
    stepCycle();
    checkOutput("t4AckT2", dbg_ack, 1);
    checkOutput("t4Rdata", dbg_rdata, 32'hA5A5_0003);
    applyStimulus(0, 0, 4'd0, 32'h0, 0, 0, 4'd0, 32'h0);
    stepCycle();
    checkOutput("t4AckT3", dbg_ack, 0);

    // Test 5: freeze in S_DBG_READ with a CPU store attempted during the freeze
    applyStimulus(0, 0, 4'd0, 32'h0, 1, 1, 4'd6, 32'h1234_5678);
    checkOutput("t5MemWe", mem_we, 1);
    stepCycle();
    clkEnable = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 4'd6, 32'h0000_0BAD, 1, 1, 4'd6, 32'h1234_5678);
      checkOutput("t5FrozenWe", mem_we, 0);
      checkOutput("t5FrozenAck", dbg_ack, 0);
      checkOutput("t5FrozenAddr", mem_addr, 4'd6);
      stepCycle();
    end
    clkEnable = 1;
    applyStimulus(0, 0, 4'd6, 32'h0, 1, 1, 4'd6, 32'h1234_5678);
    checkOutput("t5ResumeAck", dbg_ack, 0);
    stepCycle();
    checkOutput("t5Ack", dbg_ack, 1);
    applyStimulus(1, 0, 4'd6, 32'h0, 0, 0, 4'd0, 32'h0);
    stepCycle();
    checkOutput("t5AckClr", dbg_ack, 0);
    checkOutput("t5Readback", cpu_rdata, 32'h1234_5678);

    // Test 6: dbg_req held through T+3, CPU store to addr 7 in T+1
    applyStimulus(0, 0, 4'd0, 32'h0, 1, 0, 4'd2, 32'h0);
    checkOutput("t6Grant", mem_addr, 4'd2);
    checkOutput("t6WeT", mem_we, 0);
    stepCycle();
    applyStimulus(1, 1, 4'd7, 32'hCAFE_0007, 1, 0, 4'd2, 32'h0);
    checkOutput("t6WeT1", mem_we, 1);
    checkOutput("t6AddrT1", mem_addr, 4'd7);
    checkOutput("t6StallT1", cpu_stall, 0);
    stepCycle();
    applyStimulus(0, 0, 4'd8, 32'h0, 1, 0, 4'd2, 32'h0);
    checkOutput("t6AddrT2", mem_addr, 4'd8);
    checkOutput("t6AckT2", dbg_ack, 1);
    stepCycle();
    checkOutput("t6RegrantT3", mem_addr, 4'd2);
    checkOutput("t6AckT3", dbg_ack, 0);
    stepCycle();
    applyStimulus(1, 0, 4'd7, 32'h0, 0, 0, 4'd0, 32'h0);
    checkOutput("t6Ack2T1", dbg_ack, 0);
    stepCycle();
    checkOutput("t6Ack2T2", dbg_ack, 1);
    checkOutput("t6Rdata", dbg_rdata, 32'hA5A5_0002);
    checkOutput("t6CpuLoad", cpu_rdata, 32'hCAFE_0007);
    applyStimulus(0, 0, 4'd0, 32'h0, 0, 0, 4'd0, 32'h0);
    stepCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
